// File: rtl/captura_pkg.sv
// Shared types and sizing helpers for the operand-capture front end of the Booth multiplier.
package captura_pkg;

  typedef enum logic [1:0] {
    ESPERA_A = 2'd0,
    ESPERA_B = 2'd1,
    INICIO   = 2'd2,
    OCUPADO  = 2'd3
  } estado_t;

  localparam int DEB_CICLOS_DEF = 16;
  localparam int TIMEOUT_DEF    = 1024;

  // Width of a counter that must hold values 0..n-1; never narrower than one bit.
  function automatic int ancho_cnt(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/captura_operandos_antirrebote.sv
// Button debouncer: the accepted level follows boton only after DEB_CICLOS consecutive
// differing samples; pulso marks the edge where the accepted level rises.
module antirrebote
  import captura_pkg::*;
#(
  parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic estable,
  output logic pulso
);

  localparam int               CNT_W   = ancho_cnt(DEB_CICLOS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CICLOS - 1);

  logic             estable_q, estable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // pulso is combinational so the consumer can act on the very edge the level is accepted.
  always_comb begin
    estable_d = estable_q;
    cnt_d     = '0;
    pulso     = 1'b0;
    if (boton != estable_q) begin
      if (cnt_q == CNT_MAX) begin
        estable_d = boton;
        pulso     = boton;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estable_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      estable_q <= estable_d;
      cnt_q     <= cnt_d;
    end
  end

  assign estable = estable_q;

endmodule

// File: rtl/captura_operandos.sv
// Captures multiplicand then multiplier on two debounced presses, pulses start, waits for done.
// Optional done-timeout with one-cycle error pulse when CAPTURA_TIMEOUT_EN is defined.
module captura_operandos
  import captura_pkg::*;
#(
  parameter int ancho      = 4,
  parameter int DEB_CICLOS = DEB_CICLOS_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ancho-1:0] in,
  input  logic             boton,
  input  logic             done,
  output logic [ancho-1:0] op_a,
  output logic [ancho-1:0] op_b,
  output logic             start,
  output logic [1:0]       estado,
  output logic             error
);

  if (DEB_CICLOS < 2 || TIMEOUT < 2) begin : g_param_invalido
    $error("captura_operandos: DEB_CICLOS and TIMEOUT must be >= 2");
  end

  estado_t          estado_q, estado_d;
  logic [ancho-1:0] op_a_q, op_a_d;
  logic [ancho-1:0] op_b_q, op_b_d;
  logic             start_q, start_d;
  logic             boton_estable;
  logic             pulso;
  logic             press;

`ifdef CAPTURA_TIMEOUT_EN
  localparam int               TMO_W   = ancho_cnt(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             error_q, error_d;
`endif

  antirrebote #(
    .DEB_CICLOS(DEB_CICLOS)
  ) u_antirrebote (
    .clk    (clk),
    .rst    (rst),
    .boton  (boton),
    .estable(boton_estable),
    .pulso  (pulso)
  );

  // A press is only ever the rise of an accepted level that was low.
  assign press = pulso & ~boton_estable;

  always_comb begin
    estado_d = estado_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
`ifdef CAPTURA_TIMEOUT_EN
    tmo_d    = tmo_q;
    error_d  = 1'b0;
`endif
    case (estado_q)
      ESPERA_A: begin
        if (press) begin
          op_a_d   = in;
          estado_d = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (press) begin
          op_b_d   = in;
          estado_d = INICIO;
        end
      end
      INICIO: begin
        estado_d = OCUPADO;
`ifdef CAPTURA_TIMEOUT_EN
        tmo_d    = '0;
`endif
      end
      OCUPADO: begin
        // done wins over a timeout expiring on the same edge.
        if (done) begin
          estado_d = ESPERA_A;
        end
`ifdef CAPTURA_TIMEOUT_EN
        else if (tmo_q == TMO_MAX) begin
          estado_d = ESPERA_A;
          error_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: estado_d = ESPERA_A;
    endcase
    start_d = (estado_d == INICIO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= ESPERA_A;
      op_a_q   <= '0;
      op_b_q   <= '0;
      start_q  <= 1'b0;
`ifdef CAPTURA_TIMEOUT_EN
      tmo_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      start_q  <= start_d;
`ifdef CAPTURA_TIMEOUT_EN
      tmo_q    <= tmo_d;
      error_q  <= error_d;
`endif
    end
  end

  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign start  = start_q;
  assign estado = estado_q;
`ifdef CAPTURA_TIMEOUT_EN
  assign error  = error_q;
`else
  assign error  = 1'b0;
`endif

endmodule

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
- Sits directly downstream of the two-flip-flop input synchronizer in the Booth multiplier datapath. It consumes the already-synchronized switch bus and the synchronized load push-button.
- Debounces the button and latches two operands on successive presses: multiplicand first, multiplier second.
- Issues a one-cycle start pulse to the Booth multiplier, then waits for its done before accepting new operands.

Parameters:
- ancho, 4, width of the switch bus and of each operand.
- DEB_CICLOS, 16, consecutive cycles the button must hold a new level before it is accepted (>=2).
- TIMEOUT, 1024, maximum cycles to wait for done (used only with CAPTURA_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  ancho  synchronized switch bus (operand value).
- boton  input  1  synchronized load button, active-high.
- done  input  1  one-cycle pulse from the Booth multiplier: product ready.
- op_a  output  ancho  latched multiplicand.
- op_b  output  ancho  latched multiplier.
- start  output  1  one-cycle pulse: operands valid, begin multiplication.
- estado  output  2  current FSM state encoding.
- error  output  1  one-cycle timeout pulse (0 when the feature is absent).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Every register clears only on a clk edge with rst=1.
- Reset values:
  - op_a=0, op_b=0, start=0, error=0.
  - estado=ESPERA_A (2'd0).
  - Debounce stable level=0, debounce counter=0, timeout counter=0.
- Debounce:
  - If boton differs from the stable level, cnt increments.
  - If boton equals the stable level, cnt clears to 0.
  - On an edge where boton differs and cnt==DEB_CICLOS-1, the stable level takes boton and cnt clears.
  - A glitch shorter than DEB_CICLOS cycles never changes the stable level.
- Press event:
  - Asserted on the edge where the stable level goes 0->1.
  - If boton is first sampled high at edge t and stays high, the press occurs at edge t+DEB_CICLOS-1.
  - Release (1->0) produces no event.
- FSM states and transitions (encoding 0..3):
  - ESPERA_A: on a press, op_a<=in sampled at that same edge; go to ESPERA_B.
  - ESPERA_B: on a press, op_b<=in; go to INICIO.
  - INICIO: start=1 for exactly this one cycle; go to OCUPADO unconditionally.
  - OCUPADO: on done=1, go to ESPERA_A.
- Ignored inputs:
  - Presses in INICIO or OCUPADO are ignored; the debounce still tracks the level.
  - done outside OCUPADO is ignored.
- Output stability: op_a and op_b hold their values until the next capture, including through OCUPADO. The multiplier may read them at any cycle after start.
- start is a registered output, asserted during the cycle estado==INICIO. Latency from the second press edge to start high is 1 cycle.
- Holding the button produces exactly one event; a new event requires release plus a re-press, both stable.
- Reset mid-operation (any state) returns to ESPERA_A next edge, clears op_a/op_b, and suppresses any pending start.

Optional Feature:
- Macro CAPTURA_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to OCUPADO and increments each cycle in OCUPADO.
  - If it reaches TIMEOUT-1 without done, next edge: estado->ESPERA_A and error=1 for one cycle. op_a/op_b retain their values.
  - done on the same edge as the timeout takes priority: no error.
- Not defined: error tied to 0; no counter logic; OCUPADO waits indefinitely.

Decomposition:
- Package captura_pkg:
  - estado_t enum {ESPERA_A=2'd0, ESPERA_B=2'd1, INICIO=2'd2, OCUPADO=2'd3}.
  - Localparam helpers for counter widths ($clog2(DEB_CICLOS), $clog2(TIMEOUT)).
- One sub-module: antirrebote (clk, rst, boton -> estable, pulso), parameterised by DEB_CICLOS and holding the counter and stable level.
- The FSM and operand registers live in captura_operandos.

Test Plan (ancho=4, DEB_CICLOS=4, TIMEOUT=8):
- Reset: rst=1 for 2 cycles with boton=1 -> all outputs 0, estado=0; after release no event until boton has been stable 4 cycles.
- Glitch: boton high 3 cycles then low -> estado stays 0, op_a stays 0.
- Normal flow:
  - in=4'h5, boton high from edge t -> op_a=5, estado=1 at edge t+3.
  - Release 4 cycles, then in=4'hA and press -> op_b=A, estado=2.
  - Next cycle start=1 for one cycle, estado=3.
  - done pulse -> estado=0; op_a=5 and op_b=A are retained.
- Ignore while busy: press during OCUPADO with in=4'hF -> op_a/op_b unchanged; start not re-asserted.
- Held button: boton held high 20 cycles in ESPERA_A -> exactly one capture; estado=1 and no advance to 2.
- Timeout (CAPTURA_TIMEOUT_EN): no done for 8 cycles in OCUPADO -> error=1 one cycle, estado=0. Repeat with done on cycle 8 -> estado=0, error=0.
